// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
//   BLANK_CODE  : digit code the segment decoder renders as all-off
//   SLOT_*      : scan slot indices (sel values)
//   state_e     : handshake/conversion FSM encoding
//   add3        : shift-add-3 digit correction step
package seg_scan_ctrl_pkg;

  localparam logic [3:0] BLANK_CODE = 4'd11;

  localparam logic [1:0] SLOT_UNITS = 2'd0;
  localparam logic [1:0] SLOT_TENS  = 2'd1;
  localparam logic [1:0] SLOT_HUND  = 2'd2;
  localparam logic [1:0] SLOT_SIGN  = 2'd3;

  typedef enum logic {
    StIdle = 1'b0,
    StConv = 1'b1
  } state_e;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and begin converting (ignored while busy)
//   bin[7:0]   : value to convert
//   busy       : conversion in progress
//   done       : one-cycle pulse; bcd2..bcd0 hold the final result this cycle
//   bcd2/1/0   : hundreds / tens / units
// The first of the 8 iterations is folded into the load edge, so the result
// is in the register after 8 edges and done is seen ahead of the 9th edge.
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  // [19:8] BCD digits (hundreds, tens, units), [7:0] remaining binary bits
  logic [19:0] r_sr;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [19:0] w_sr_adj;

  always_comb begin
    w_sr_adj = {add3(r_sr[19:16]), add3(r_sr[15:12]), add3(r_sr[11:8]), r_sr[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (!r_busy) begin
      if (start) begin
        r_sr   <= {11'd0, bin, 1'b0};
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end else if (r_cnt != 3'd7) begin
      r_sr  <= w_sr_adj << 1;
      r_cnt <= r_cnt + 3'd1;
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == 3'd7);
  assign bcd2 = r_sr[19:16];
  assign bcd1 = r_sr[15:12];
  assign bcd0 = r_sr[11:8];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-slot multiplexed seven-segment scan controller with an 8-bit
// valid/ready value input converted to BCD.
//   clk, rst_n       : clock, asynchronous active-low reset
//   val_valid/ready  : input handshake, val_data[7:0] captured on transfer
//   digit[3:0]       : BCD code of the current slot (BLANK_CODE = blank)
//   sel[1:0]         : current slot (units, tens, hundreds, sign)
//   an[3:0]          : active-low anodes, all off during slot dead time
// Build option: define LZ_BLANK_EN to blank leading zeros of hundreds/tens.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       val_valid,
  input  logic [7:0] val_data,
  output logic       val_ready,
  output logic [3:0] digit,
  output logic [1:0] sel,
  output logic [3:0] an
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);

  state_e          r_state, w_state_d;
  logic            w_xfer, w_busy, w_done;
  logic [3:0]      w_bcd2, w_bcd1, w_bcd0;
  logic [3:0]      r_hund, r_tens, r_units;
  logic [3:0]      w_hund_d, w_tens_d, w_units_d;
  logic [PreW-1:0] r_pre, w_pre_d;
  logic [1:0]      r_sel, w_sel_d;
  logic [3:0]      r_an, w_an_d;
  logic [3:0]      r_digit, w_digit_d;

  function automatic logic [3:0] slot_digit(input logic [1:0] s, input logic [3:0] h,
                                            input logic [3:0] t, input logic [3:0] u);
    logic [3:0] dh, dt;
`ifdef LZ_BLANK_EN
    dh = (h == 4'd0) ? BLANK_CODE : h;
    dt = (h == 4'd0 && t == 4'd0) ? BLANK_CODE : t;
`else
    dh = h;
    dt = t;
`endif
    unique case (s)
      SLOT_UNITS: return u;
      SLOT_TENS:  return dt;
      SLOT_HUND:  return dh;
      SLOT_SIGN:  return BLANK_CODE;
    endcase
  endfunction

  assign w_xfer = val_valid && val_ready;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_xfer),
    .bin   (val_data),
    .busy  (w_busy),
    .done  (w_done),
    .bcd2  (w_bcd2),
    .bcd1  (w_bcd1),
    .bcd0  (w_bcd0)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_xfer) w_state_d = StConv;
      StConv: if (w_done) w_state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    val_ready = (r_state == StIdle) && !w_busy;
  end

  // Display only ever takes a completed result, all three digits together
  always_comb begin
    w_hund_d  = w_done ? w_bcd2 : r_hund;
    w_tens_d  = w_done ? w_bcd1 : r_tens;
    w_units_d = w_done ? w_bcd0 : r_units;
  end

  always_comb begin
    if (r_pre == PreW'(SCAN_DIV - 1)) begin
      w_pre_d = '0;
      w_sel_d = r_sel + 2'd1;
    end else begin
      w_pre_d = r_pre + 1'b1;
      w_sel_d = r_sel;
    end
    // an and digit are registered from next-state values so they line up
    // exactly with r_pre/r_sel while staying glitch-free
    w_an_d    = (w_pre_d < PreW'(BLANK_CYC)) ? 4'b1111 : ~(4'b0001 << w_sel_d);
    w_digit_d = slot_digit(w_sel_d, w_hund_d, w_tens_d, w_units_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hund  <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_pre   <= '0;
      r_sel   <= SLOT_UNITS;
      r_an    <= 4'b1111;
      r_digit <= BLANK_CODE;
    end else begin
      r_hund  <= w_hund_d;
      r_tens  <= w_tens_d;
      r_units <= w_units_d;
      r_pre   <= w_pre_d;
      r_sel   <= w_sel_d;
      r_an    <= w_an_d;
      r_digit <= w_digit_d;
    end
  end

  assign sel   = r_sel;
  assign an    = r_an;
  assign digit = r_digit;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       val_valid = 1'b0;
  logic [7:0] val_data = 8'd0;
  logic       val_ready;
  logic [3:0] digit;
  logic [1:0] sel;
  logic [3:0] an;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_val = 0;
  int low_cnt = 0;
  bit prev_ready = 1'b1;
  int q[$];

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val_valid (val_valid),
    .val_data  (val_data),
    .val_ready (val_ready),
    .digit     (digit),
    .sel       (sel),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Edges since reset release; scan position follows from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int exp_digit(input int s, input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (s)
      0: return u;
`ifdef LZ_BLANK_EN
      1: return (h == 0 && t == 0) ? 11 : t;
      2: return (h == 0) ? 11 : h;
`else
      1: return t;
      2: return h;
`endif
      default: return 11;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", 32'(val_ready), 1);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_an", 32'(an), 4'b1111);
    chk("rst_digit", 32'(digit), 11);
  endtask

  // Advance one cycle, sample at the falling edge, retire scoreboard entries
  task automatic step();
    int s, pre;
    @(negedge clk);
    if (!val_ready) begin
      low_cnt++;
      if (low_cnt > 20) chk("ready_timeout", 32'(low_cnt), 8);
    end else if (!prev_ready) begin
      chk("latency", 32'(low_cnt), 8);
      chk("sb_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) model_val = q.pop_front();
      low_cnt = 0;
    end
    prev_ready = val_ready;
    s   = (cyc / SD) % 4;
    pre = cyc % SD;
    chk("sel", 32'(sel), 32'(s));
    chk("an", 32'(an), (pre < BC) ? 32'hF : 32'(~(4'b0001 << s) & 4'hF));
    chk("digit", 32'(digit), 32'(exp_digit(s, model_val)));
  endtask

  task automatic run(input int n, input bit v, input int d);
    for (int i = 0; i < n; i++) begin
      val_valid = v;
      val_data  = 8'(d);
      if (v && val_ready) q.push_back(d);
      step();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    // Idle scan: two full rotations of all four slots
    run(64, 1'b0, 0);

    // Full-scale value
    run(1, 1'b1, 255);
    run(40, 1'b0, 0);

    // Small value exercises leading-zero blanking
    run(1, 1'b1, 7);
    run(40, 1'b0, 0);

    // valid held through conversion; second value waits for ready
    run(1, 1'b1, 100);
    run(9, 1'b1, 42);
    run(40, 1'b0, 0);

    // Reset mid-conversion discards the value
    run(1, 1'b1, 199);
    run(4, 1'b0, 0);
    rst_n = 1'b0;
    q.delete();
    model_val  = 0;
    low_cnt    = 0;
    prev_ready = 1'b1;
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    run(40, 1'b0, 0);
    run(1, 1'b1, 199);
    run(40, 1'b0, 0);

    chk("sb_drained", 32'(q.size()), 0);
    chk("final_val", 32'(model_val), 199);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
